alu_op_sequencer: RTL and testbench

- Control-side counterpart of the 8-bit CPU ALU. Fetches 16-bit instructions from program memory over a valid handshake, decodes them, and drives ALU operands A/B and the 8-bit ALU instruction byte.
- Captures the registered ALU result Y one cycle after issue and writes it back into a 4x8 register file.
- Computes and holds the carry/borrow flag itself, because the ALU exports no flags. It feeds this flag back on ALU instr bit 5 for carry-chained operations.

---
 rtl/alu_op_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Control-side sequencer for the 8-bit ALU. It fetches 16-bit instructions over
// a valid handshake, decodes them, and drives the ALU operands and instruction
// byte. It captures the registered ALU result into a 4-entry register file. It
// also keeps the carry/borrow flag, because the ALU exports no flags.
//
// Build option: define SINGLE_STEP_EN to add a `step` input and a PAUSE state.
// With it defined, every completed instruction (WB, LDI, JMP) parks in PAUSE.
// Fetching resumes when step=1. HALT still goes directly to HALTED.
module alu_op_sequencer #(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic                  imem_rd,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [15:0]           imem_data,
    input  logic                  imem_valid,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [7:0]            alu_instr,
    input  logic [DATA_WIDTH-1:0] alu_y,
    output logic                  carry_flag,
    output logic                  busy,
    output logic                  halted
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
`ifdef SINGLE_STEP_EN
        ,
        S_PAUSE  = 3'd6
`endif
    } state_t;

    // Where a finished instruction goes next: straight back to FETCH, or
    // park in PAUSE when single-stepping is built in.
`ifdef SINGLE_STEP_EN
    localparam state_t S_DONE = S_PAUSE;
`else
    localparam state_t S_DONE = S_FETCH;
`endif

    // Instruction classes, IR[15:14]
    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LDI  = 2'b01;
    localparam logic [1:0] CLS_JMP  = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Instruction class field
    function automatic logic [1:0] ir_class(input logic [15:0] ir);
        return ir[15:14];
    endfunction

    // Destination register index (ALU and LDI)
    function automatic logic [1:0] ir_dst(input logic [15:0] ir);
        return ir[13:12];
    endfunction

    // Source A register index (ALU)
    function automatic logic [1:0] ir_src_a(input logic [15:0] ir);
        return ir[11:10];
    endfunction

    // Source B register index (ALU)
    function automatic logic [1:0] ir_src_b(input logic [15:0] ir);
        return ir[9:8];
    endfunction

    // Immediate of LDI, zero-extended or truncated to the datapath width
    function automatic logic [DATA_WIDTH-1:0] ir_imm(input logic [15:0] ir);
        return DATA_WIDTH'(ir[7:0]);
    endfunction

    // JMP target, zero-extended or truncated to the pc width
    function automatic logic [PC_WIDTH-1:0] ir_target(input logic [15:0] ir);
        return PC_WIDTH'(ir[7:0]);
    endfunction

    // Carry-in that is issued on alu_instr[5]. With use_carry set, the held
    // flag is chained in; otherwise the literal cin bit is used.
    function automatic logic issue_cin(input logic [15:0] ir, input logic cur_carry);
        return ir[6] ? cur_carry : ir[5];
    endfunction

    // New carry/borrow flag after a writeback. It is computed from the issued
    // operands and instruction bits, because the ALU itself reports no flags.
    function automatic logic carry_next(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [3:0]            opcode,
        input logic                  op,
        input logic                  cin,
        input logic                  cur
    );
        logic [DATA_WIDTH:0] wide;
        logic                res;
        wide = {(DATA_WIDTH+1){1'b0}};
        case (opcode)
            4'b0000: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[DATA_WIDTH];
            end
            4'b0001: begin
                wide = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
                res  = wide[DATA_WIDTH];
            end
            4'b0010: begin
                res = (a < b);
            end
            4'b0011: begin
                // b + cin may overflow DATA_WIDTH, so the compare is done one bit wider
                wide = {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
                res  = ({1'b0, a} < wide);
            end
            4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
                // shift/rotate family: the bit that falls off the end
                res = op ? a[DATA_WIDTH-1] : a[0];
            end
            default: begin
                res = cur;
            end
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] regs_q [4];
    logic [DATA_WIDTH-1:0] regs_d [4];
    logic                  carry_q, carry_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [7:0]            alu_instr_q, alu_instr_d;
    logic                  imem_rd_q, imem_rd_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;

    logic [PC_WIDTH-1:0]   pc_inc_s;

    assign pc_inc_s = pc_q + PC_WIDTH'(1'b1);

    // Next-state, datapath and registered-output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        carry_d     = carry_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_instr_d = alu_instr_q;

        case (state_q)
            S_IDLE, S_HALTED: begin
                // Registers and flag are kept, so a restarted program sees them.
                if (start) begin
                    pc_d    = {PC_WIDTH{1'b0}};
                    state_d = S_FETCH;
                end else begin
                    state_d = state_q;
                end
            end

            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_DECODE: begin
                case (ir_class(ir_q))
                    CLS_ALU: begin
                        // Operands are sampled here, before writeback, so dst == src is safe.
                        alu_a_d     = regs_q[ir_src_a(ir_q)];
                        alu_b_d     = regs_q[ir_src_b(ir_q)];
                        alu_instr_d = {2'b00, issue_cin(ir_q, carry_q), ir_q[4], ir_q[3:0]};
                        state_d     = S_ISSUE;
                    end
                    CLS_LDI: begin
                        regs_d[ir_dst(ir_q)] = ir_imm(ir_q);
                        pc_d                 = pc_inc_s;
                        state_d              = S_DONE;
                    end
                    CLS_JMP: begin
                        if (!ir_q[8] || carry_q) begin
                            pc_d = ir_target(ir_q);
                        end else begin
                            pc_d = pc_inc_s;
                        end
                        state_d = S_DONE;
                    end
                    CLS_HALT: begin
                        state_d = S_HALTED;
                    end
                    default: begin
                        state_d = S_HALTED;
                    end
                endcase
            end

            S_ISSUE: begin
                // alu_* hold still; the ALU registers Y at the end of this cycle.
                state_d = S_WB;
            end

            S_WB: begin
                regs_d[ir_dst(ir_q)] = alu_y;
                carry_d = carry_next(alu_a_q, alu_b_q, alu_instr_q[3:0],
                                     alu_instr_q[4], alu_instr_q[5], carry_q);
                pc_d    = pc_inc_s;
                state_d = S_DONE;
            end

`ifdef SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_PAUSE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered, so they are derived from the next state.
        imem_rd_d = (state_d == S_FETCH);
        halted_d  = (state_d == S_HALTED);
        busy_d    = (state_d != S_IDLE) && (state_d != S_HALTED);
    end

    // All sequencer flops; reset aborts any operation immediately and drops a pending fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= {PC_WIDTH{1'b0}};
            ir_q        <= 16'h0000;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
            carry_q     <= 1'b0;
            alu_a_q     <= {DATA_WIDTH{1'b0}};
            alu_b_q     <= {DATA_WIDTH{1'b0}};
            alu_instr_q <= 8'h00;
            imem_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            carry_q     <= carry_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_instr_q <= alu_instr_d;
            imem_rd_q   <= imem_rd_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign imem_rd    = imem_rd_q;
    assign imem_addr  = pc_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_instr  = alu_instr_q;
    assign carry_flag = carry_q;
    assign busy       = busy_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Lockstep instruction-level reference: at each fetch, the bench compares the DUT
// with an ISA model. The model is updated from the fetched word, and a
// behavioural registered ALU supplies alu_y.
module tb_alu_op_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_instr;
    logic [7:0]  alu_y;
    logic        carry_flag;
    logic        busy;
    logic        halted;
`ifdef SINGLE_STEP_EN
    logic        step;
`endif

    logic [15:0] imem [256];
    int          n_vec;
    int          n_err;

    // instruction-level model state
    int          m_pc;
    logic [7:0]  m_r [4];
    logic        m_carry;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [7:0]  m_ins;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer #(.PC_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_instr  (alu_instr),
        .alu_y      (alu_y),
        .carry_flag (carry_flag),
        .busy       (busy),
        .halted     (halted)
    );

    // Behavioural ALU used by the environment (and the model)
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] ins);
        logic c;
        logic op;
        c  = ins[5];
        op = ins[4];
        case (ins[3:0])
            4'd0:    return a + b;
            4'd1:    return a + b + {7'd0, c};
            4'd2:    return a - b;
            4'd3:    return a - b - {7'd0, c};
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return ~a;
            4'd12:   return op ? {a[6:0], 1'b0} : {1'b0, a[7:1]};
            4'd13:   return op ? {a[6:0], c} : {c, a[7:1]};
            4'd14:   return op ? {a[6:0], a[7]} : {a[0], a[7:1]};
            4'd15:   return op ? {a[6:0], 1'b0} : {a[7], a[7:1]};
            default: return b;
        endcase
    endfunction

    // registered ALU: Y is updated at every edge from the issued operands
    always @(posedge clk) alu_y <= alu_fn(alu_a, alu_b, alu_instr);

    // Carry rule, written with plain integer arithmetic
    function automatic logic carry_model(input int a, input int b, input int c,
                                         input logic [3:0] opc, input logic op,
                                         input logic old);
        case (opc)
            4'd0:                      return (a + b) > 255;
            4'd1:                      return (a + b + c) > 255;
            4'd2:                      return a < b;
            4'd3:                      return a < (b + c);
            4'd12, 4'd13, 4'd14, 4'd15: return op ? ((a / 128) % 2 == 1) : (a % 2 == 1);
            default:                   return old;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_carry = 1'b0;
        m_a     = 8'h00;
        m_b     = 8'h00;
        m_ins   = 8'h00;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    endtask

    task automatic model_exec(input logic [15:0] w);
        int   a;
        int   b;
        logic cb;
        case (w[15:14])
            2'b00: begin
                a       = int'(m_r[w[11:10]]);
                b       = int'(m_r[w[9:8]]);
                cb      = w[6] ? m_carry : w[5];
                m_a     = m_r[w[11:10]];
                m_b     = m_r[w[9:8]];
                m_ins   = {2'b00, cb, w[4], w[3:0]};
                m_carry = carry_model(a, b, int'(cb), w[3:0], w[4], m_carry);
                m_r[w[13:12]] = alu_fn(m_a, m_b, m_ins);
                m_pc    = (m_pc + 1) % 256;
            end
            2'b01: begin
                m_r[w[13:12]] = w[7:0];
                m_pc = (m_pc + 1) % 256;
            end
            2'b10: begin
                if (!w[8] || m_carry) m_pc = int'(w[7:0]);
                else m_pc = (m_pc + 1) % 256;
            end
            default: begin
                m_pc = m_pc;
            end
        endcase
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hC000;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},    32'(imem_rd),    32'd0);
        check({tag, "_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_a"},     32'(alu_a),      32'd0);
        check({tag, "_b"},     32'(alu_b),      32'd0);
        check({tag, "_instr"}, 32'(alu_instr),  32'd0);
        check({tag, "_carry"}, 32'(carry_flag), 32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_halt"},  32'(halted),     32'd0);
    endtask

    // Start the program at pc=0 and serve fetches with random latency until HALTED
    task automatic run_prog(input int stall_addr, input bit busy_start, input bit abort_alu);
        int cyc;
        int wait_cnt;
        bit stalled;
        bit aborted;
        cyc = 0; wait_cnt = 0; stalled = 1'b0; aborted = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        m_pc = 0;
        while (halted !== 1'b1 && cyc < 3000) begin
            start = (busy_start && cyc == 6) ? 1'b1 : 1'b0;
            if (imem_valid) begin
                imem_valid = 1'b0;
                wait_cnt   = $urandom_range(0, 2);
            end else if (imem_rd === 1'b1) begin
                if (!stalled && int'(imem_addr) == stall_addr) begin
                    stalled = 1'b1;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        check("stall_rd",   32'(imem_rd),   32'd1);
                        check("stall_addr", 32'(imem_addr), 32'(stall_addr));
                        check("stall_busy", 32'(busy),      32'd1);
                    end
                end else if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    check("fetch_addr",  32'(imem_addr),  32'(m_pc));
                    check("fetch_carry", 32'(carry_flag), 32'(m_carry));
                    check("fetch_alu_a", 32'(alu_a),      32'(m_a));
                    check("fetch_alu_b", 32'(alu_b),      32'(m_b));
                    check("fetch_instr", 32'(alu_instr),  32'(m_ins));
                    check("fetch_busy",  32'(busy),       32'd1);
                    imem_data  = imem[imem_addr];
                    imem_valid = 1'b1;
                    model_exec(imem_data);
                    if (abort_alu && imem_data[15:14] == 2'b00) begin
                        @(negedge clk);          // DECODE
                        imem_valid = 1'b0;
                        @(negedge clk);          // ISSUE
                        reset = 1'b1;
                        #1;
                        check_all_zero("abort");
                        model_reset();
                        aborted = 1'b1;
                        break;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (abort_alu) begin
            check("abort_reached", 32'(aborted), 32'd1);
        end else begin
            check("timeout",     32'(cyc < 3000), 32'd1);
            check("halted",      32'(halted),     32'd1);
            check("halt_pc",     32'(imem_addr),  32'(m_pc));
            check("halt_carry",  32'(carry_flag), 32'(m_carry));
            check("halt_busy",   32'(busy),       32'd0);
            check("halt_rd",     32'(imem_rd),    32'd0);
        end
    endtask

    initial begin
        int          len;
        int          r;
        int          t;
        logic [15:0] w;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
`ifdef SINGLE_STEP_EN
        step = 1'b1;
`endif
        model_reset();
        clear_imem();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // LDI r0,F0; LDI r1,20; ADD r2=r0+r1; HALT, with a start pulse while busy
        clear_imem();
        imem[0] = 16'h40F0; imem[1] = 16'h5020; imem[2] = 16'h2100; imem[3] = 16'hC000;
        run_prog(-1, 1'b1, 1'b0);
        check("add_pc",    32'(imem_addr),  32'h03);
        check("add_carry", 32'(carry_flag), 32'd1);

        // ADC r3=r1+r1 chaining the carry, then expose r2/r3 as operands
        clear_imem();
        imem[0] = 16'h3541; imem[1] = 16'h0B04; imem[2] = 16'hC000;
        run_prog(-1, 1'b0, 1'b0);
        check("r2_add",    32'(alu_a),      32'h10);
        check("r3_adc",    32'(alu_b),      32'h41);
        check("adc_carry", 32'(carry_flag), 32'd0);

        // SUB 5-7, then conditional JMP taken to 0x10
        clear_imem();
        imem[0] = 16'h4005; imem[1] = 16'h5007; imem[2] = 16'h2102; imem[3] = 16'h8110;
        imem[16] = 16'h3A04; imem[17] = 16'hC000;
        run_prog(-1, 1'b0, 1'b0);
        check("sub_res",   32'(alu_a),      32'hFE);
        check("jmp_taken", 32'(imem_addr),  32'h11);
        check("sub_carry", 32'(carry_flag), 32'd1);

        // clear carry, same conditional JMP falls through
        clear_imem();
        imem[0] = 16'h4000; imem[1] = 16'h0000; imem[2] = 16'h8110; imem[3] = 16'hC000;
        run_prog(-1, 1'b0, 1'b0);
        check("jmp_fall", 32'(imem_addr), 32'h03);

        // ROL 0x81 and LSR 0x02
        clear_imem();
        imem[0] = 16'h4081; imem[1] = 16'h101E; imem[2] = 16'h6002; imem[3] = 16'h380C;
        imem[4] = 16'h0704; imem[5] = 16'hC000;
        run_prog(-1, 1'b0, 1'b0);
        check("rol_res",   32'(alu_a),      32'h03);
        check("lsr_res",   32'(alu_b),      32'h01);
        check("lsr_carry", 32'(carry_flag), 32'd0);

        // pc wrap 0xFF -> 0x00 via LDI, with a 5-cycle fetch stall at 0xFD
        clear_imem();
        imem[0] = 16'h8102; imem[1] = 16'h80FD; imem[2] = 16'hC000;
        imem[253] = 16'h4080; imem[254] = 16'h001E; imem[255] = 16'h505A;
        run_prog(253, 1'b0, 1'b0);
        check("wrap_pc", 32'(imem_addr), 32'h02);

        // reset asserted during ISSUE, then a late imem_valid while IDLE
        clear_imem();
        imem[0] = 16'h4007; imem[1] = 16'h1000; imem[2] = 16'hC000;
        run_prog(-1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        imem_data  = 16'h4000;
        imem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy),    32'd0);
            check("idle_rd",   32'(imem_rd), 32'd0);
            check("idle_halt", 32'(halted),  32'd0);
        end
        imem_valid = 1'b0;
        clear_imem();
        imem[0] = 16'h0104; imem[1] = 16'hC000;
        run_prog(-1, 1'b0, 1'b0);
        check("rst_r0", 32'(alu_a), 32'h00);
        check("rst_r1", 32'(alu_b), 32'h00);

        // random forward-only programs, registers and flag carried across runs
        for (int p = 0; p < 25; p++) begin
            clear_imem();
            len = $urandom_range(4, 12);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (r < 5) begin
                    w = 16'($urandom) & 16'h3FFF;
                end else if (r < 8) begin
                    w = 16'h4000 | (16'($urandom) & 16'h30FF);
                end else begin
                    t = $urandom_range(i + 1, len);
                    w = 16'h8000 | (16'($urandom_range(0, 1)) << 8) | 16'(t);
                end
                imem[i] = w;
            end
            imem[len]     = 16'h0104;
            imem[len + 1] = 16'h0B04;
            imem[len + 2] = 16'hC000;
            run_prog(-1, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
